// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage request and pipeline-control signals between the decode stage and the
// hazard scoreboard.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW = 5
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic [REG_AW-1:0] id_rd;
  logic              id_mem_read;
  logic              id_branch_taken;
  logic              id_jump;
  logic              id_jump_reg;
  logic              pc_write;
  logic              if_id_write;
  logic              ctrl_bubble;
  logic              if_id_flush;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_rd,
    output id_mem_read, id_branch_taken, id_jump, id_jump_reg,
    input  pc_write, if_id_write, ctrl_bubble, if_id_flush
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write, id_rd,
    input  id_mem_read, id_branch_taken, id_jump, id_jump_reg,
    output pc_write, if_id_write, ctrl_bubble, if_id_flush
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: tracks in-flight destinations in a shift-pipe scoreboard and
// produces stall / bubble / IF-ID flush controls plus a saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DEPTH        = 3,
  parameter bit          FWD_EN       = 1'b0,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  hazard_scoreboard_unit_if.slave bus,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [DEPTH-1:0]             sb_v_q, sb_v_d;
  logic [DEPTH-1:0][REG_AW-1:0] sb_rd_q, sb_rd_d;
  // Load flag only matters in EX and MEM, so it is not carried further down the pipe.
  logic [1:0]                   sb_ld_q, sb_ld_d;
  logic [FW-1:0]                flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic             flush_active;
  logic             rs_used, rt_used, cf_use;
  logic [DEPTH-1:0] match;
  logic             haz_fwd, haz_nofwd, hazard;
  logic             stall, redirect, issue;

  always_comb begin
    rs_used = bus.id_uses_rs | bus.id_jump_reg | bus.id_branch_taken;
    rt_used = bus.id_uses_rt | bus.id_branch_taken;
    cf_use  = bus.id_branch_taken | bus.id_jump_reg;
    match   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      match[k] = sb_v_q[k] &
                 ((rs_used & (sb_rd_q[k] == bus.id_rs) & (bus.id_rs != '0)) |
                  (rt_used & (sb_rd_q[k] == bus.id_rt) & (bus.id_rt != '0)));
    end
    haz_nofwd = |match;
    // Branch/jr resolve in ID, so they also wait out an ALU result in EX and a load in MEM.
    haz_fwd   = (match[0] & sb_ld_q[0]) |
                (cf_use & (match[0] | (match[1] & sb_ld_q[1])));
    hazard    = FWD_EN ? haz_fwd : haz_nofwd;
  end

  assign flush_active = (flush_cnt_q != '0);
  assign stall        = bus.id_valid & ~flush_active & hazard;
  assign issue        = bus.id_valid & ~flush_active & ~stall;
  assign redirect     = issue & (bus.id_jump | bus.id_branch_taken | bus.id_jump_reg);

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.ctrl_bubble = 1'b0;
    bus.if_id_flush = 1'b0;
    if (Reset) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.ctrl_bubble = 1'b1;
    end else if (flush_active) begin
      bus.ctrl_bubble = 1'b1;
      bus.if_id_flush = 1'b1;
    end else if (stall) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.ctrl_bubble = 1'b1;
    end else if (redirect) begin
      bus.if_id_flush = 1'b1;
    end
  end

  always_comb begin
    sb_v_d[0]  = issue & bus.id_reg_write & (bus.id_rd != '0);
    sb_rd_d[0] = bus.id_rd;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_v_d[k]  = sb_v_q[k-1];
      sb_rd_d[k] = sb_rd_q[k-1];
    end
    sb_ld_d = {sb_ld_q[0], issue & bus.id_mem_read};

    if (flush_active) begin
      flush_cnt_d = flush_cnt_q - FW'(1);
    end else if (redirect) begin
      flush_cnt_d = FW'(FLUSH_CYCLES - 1);
    end else begin
      flush_cnt_d = '0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sb_v_q      <= '0;
      sb_rd_q     <= '0;
      sb_ld_q     <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_v_q      <= sb_v_d;
      sb_rd_q     <= sb_rd_d;
      sb_ld_q     <= sb_ld_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
